// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port between the fetch unit and a synchronous imem.
interface instruction_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_rd_en;
    logic [DATA_WIDTH-1:0] imem_rdata;

    // Fetch unit side: issues address and read strobe, receives the word.
    modport master (
        output imem_addr,
        output imem_rd_en,
        input  imem_rdata
    );

    // Memory side: rdata updates on the edge after an enabled read, else holds.
    modport slave (
        input  imem_addr,
        input  imem_rd_en,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, picks sequential/branch/jump next PC, drives the
// synchronous instruction memory and presents instruction + PC+4 to IF/ID.
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] HALT_INSTR = '1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    instruction_fetch_unit_if.master imem,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [ADDR_WIDTH-1:0] if_id_pc_plus4,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic                  if_id_valid,
    output logic                  halted
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
    logic                  valid_q, valid_d;

    logic                  run_en;
    logic                  redirect;
    logic                  halt_seen;
    logic                  halt_go;
    logic                  advance;
    logic [ADDR_WIDTH-1:0] seq_pc;
    logic [ADDR_WIDTH-1:0] next_pc;

    // Sequential PC wraps naturally at the address width.
    assign seq_pc = pc_q + ADDR_WIDTH'(4);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: IDLE waits for enable, RUN leaves only on an unstalled halt.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable) state_d = S_RUN;
            S_RUN:   if (halt_go) state_d = S_HALT;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs / control strobes. Halt beats redirect; redirect beats stall.
    always_comb begin
        run_en          = (state_q == S_RUN) && enable;
        halt_seen       = valid_q && (imem.imem_rdata == HALT_INSTR);
        redirect        = run_en && (jump || branch_taken);
        halt_go         = run_en && halt_seen && !stall;
        advance         = run_en && !halt_seen && (!stall || redirect);
        imem.imem_rd_en = advance;
        halted          = (state_q == S_HALT);
    end

    // Next PC select: jump over branch over sequential, targets word-aligned.
    always_comb begin
        next_pc = seq_pc;
        if (jump)              next_pc = {jump_target[ADDR_WIDTH-1:2], 2'b00};
        else if (branch_taken) next_pc = {branch_target[ADDR_WIDTH-1:2], 2'b00};
    end

    // PC and IF/ID next values: move on advance, drop valid on redirect or halt.
    always_comb begin
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (advance) begin
            pc_d       = next_pc;
            pc_plus4_d = seq_pc;
            valid_d    = !redirect;
        end else if (halt_go) begin
            valid_d    = 1'b0;
        end
    end

    // PC and IF/ID registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    // Memory address tracks the PC; flushed slots present a NOP.
    always_comb begin
        imem.imem_addr = pc_q;
        pc_out         = pc_q;
        if_id_pc_plus4 = pc_plus4_q;
        if_id_valid    = valid_q;
        if_id_instr    = valid_q ? imem.imem_rdata : '0;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a synchronous imem model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, enable, stall, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc_out, if_id_pc_plus4, if_id_instr;
    logic        if_id_valid, halted;
    logic [31:0] w_pc_out, w_if_id_pc_plus4, w_if_id_instr;
    logic        w_if_id_valid, w_halted;
    logic        halt_en;
    int          checks = 0;
    int          passed = 0;

    instruction_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    instruction_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wbus ();

    instruction_fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .imem(bus.master),
        .pc_out(pc_out), .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_instr(if_id_instr), .if_id_valid(if_id_valid), .halted(halted)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(reset), .enable(enable), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .imem(wbus.master),
        .pc_out(w_pc_out), .if_id_pc_plus4(w_if_id_pc_plus4),
        .if_id_instr(w_if_id_instr), .if_id_valid(w_if_id_valid), .halted(w_halted)
    );

    always #5 clk = ~clk;

    // Memory contents: address-derived pattern, optional halt word at 16.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (halt_en && a == 32'd16) return 32'hFFFF_FFFF;
        return a ^ 32'h1357_0000;
    endfunction

    initial begin
        bus.imem_rdata  = '0;
        wbus.imem_rdata = '0;
    end
    always @(posedge clk) if (bus.imem_rd_en)  bus.imem_rdata  <= mem_word(bus.imem_addr);
    always @(posedge clk) if (wbus.imem_rd_en) wbus.imem_rdata <= mem_word(wbus.imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        halt_en = 1'b0;
        do_reset();
        #1;
        checks++; if (pc_out !== 32'h0) $display("FAIL reset_pc got %h want %h", pc_out, 32'h0); else passed++;
        checks++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", if_id_valid); else passed++;
        checks++; if (if_id_pc_plus4 !== 32'h0) $display("FAIL reset_plus4 got %h want 0", if_id_pc_plus4); else passed++;
        checks++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else passed++;
        checks++; if (bus.imem_rd_en !== 1'b0) $display("FAIL reset_rd_en got %b want 0", bus.imem_rd_en); else passed++;
        checks++; if (w_pc_out !== 32'hFFFF_FFFC) $display("FAIL reset_pc_w got %h want fffffffc", w_pc_out); else passed++;
        tick();  // IDLE with enable low: nothing moves
        checks++; if (pc_out !== 32'h0 || bus.imem_rd_en !== 1'b0) $display("FAIL idle_hold pc %h rd_en %b want 0/0", pc_out, bus.imem_rd_en); else passed++;
    endtask

    task automatic test_sequential();
        enable = 1'b1;
        tick();  // IDLE -> RUN
        checks++; if (pc_out !== 32'h0 || bus.imem_rd_en !== 1'b1 || if_id_valid !== 1'b0)
            $display("FAIL run_entry pc %h rd_en %b valid %b want 0/1/0", pc_out, bus.imem_rd_en, if_id_valid); else passed++;
        tick();
        checks++; if (pc_out !== 32'h4) $display("FAIL seq_pc1 got %h want 4", pc_out); else passed++;
        checks++; if (if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h4 || if_id_instr !== 32'h1357_0000)
            $display("FAIL seq_ifid1 valid %b plus4 %h instr %h want 1/4/13570000", if_id_valid, if_id_pc_plus4, if_id_instr); else passed++;
        tick();
        checks++; if (pc_out !== 32'h8 || if_id_pc_plus4 !== 32'h8 || if_id_instr !== 32'h1357_0004)
            $display("FAIL seq_ifid2 pc %h plus4 %h instr %h want 8/8/13570004", pc_out, if_id_pc_plus4, if_id_instr); else passed++;
    endtask

    task automatic test_stall();
        stall = 1'b1;
        #1;
        checks++; if (bus.imem_rd_en !== 1'b0) $display("FAIL stall_rd_en got %b want 0", bus.imem_rd_en); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc_out !== 32'h8 || if_id_instr !== 32'h1357_0004 || if_id_valid !== 1'b1)
                $display("FAIL stall_hold%0d pc %h instr %h valid %b want 8/13570004/1", i, pc_out, if_id_instr, if_id_valid); else passed++;
        end
        stall = 1'b0;
        tick();
        checks++; if (pc_out !== 32'hC || if_id_instr !== 32'h1357_0008 || if_id_pc_plus4 !== 32'hC)
            $display("FAIL stall_resume pc %h instr %h plus4 %h want c/13570008/c", pc_out, if_id_instr, if_id_pc_plus4); else passed++;
    endtask

    task automatic test_branch();
        branch_taken = 1'b1; branch_target = 32'h41;
        tick();
        branch_taken = 1'b0;
        checks++; if (pc_out !== 32'h40) $display("FAIL branch_pc got %h want 40", pc_out); else passed++;
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0)
            $display("FAIL branch_flush valid %b instr %h want 0/0", if_id_valid, if_id_instr); else passed++;
        tick();
        checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h1357_0040 || if_id_pc_plus4 !== 32'h44 || pc_out !== 32'h44)
            $display("FAIL branch_target valid %b instr %h plus4 %h pc %h want 1/13570040/44/44",
                     if_id_valid, if_id_instr, if_id_pc_plus4, pc_out); else passed++;
    endtask

    task automatic test_jump_over_stall();
        stall = 1'b1; jump = 1'b1; jump_target = 32'h100;
        branch_taken = 1'b1; branch_target = 32'h200;
        #1;
        checks++; if (bus.imem_rd_en !== 1'b1) $display("FAIL redirect_rd_en got %b want 1", bus.imem_rd_en); else passed++;
        tick();
        stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        checks++; if (pc_out !== 32'h100 || if_id_valid !== 1'b0)
            $display("FAIL jump_pc pc %h valid %b want 100/0", pc_out, if_id_valid); else passed++;
        tick();
        checks++; if (pc_out !== 32'h104 || if_id_instr !== 32'h1357_0100 || if_id_pc_plus4 !== 32'h104)
            $display("FAIL jump_target pc %h instr %h plus4 %h want 104/13570100/104", pc_out, if_id_instr, if_id_pc_plus4); else passed++;
    endtask

    task automatic test_halt();
        halt_en = 1'b1;
        do_reset();
        enable = 1'b1;
        tick();  // RUN, pc=0
        for (int i = 0; i < 5; i++) tick();
        checks++; if (pc_out !== 32'd20 || if_id_instr !== 32'hFFFF_FFFF || halted !== 1'b0 || bus.imem_rd_en !== 1'b0)
            $display("FAIL halt_seen pc %h instr %h halted %b rd_en %b want 14/ffffffff/0/0",
                     pc_out, if_id_instr, halted, bus.imem_rd_en); else passed++;
        stall = 1'b1;
        tick();
        checks++; if (halted !== 1'b0 || if_id_valid !== 1'b1 || pc_out !== 32'd20)
            $display("FAIL halt_stalled halted %b valid %b pc %h want 0/1/14", halted, if_id_valid, pc_out); else passed++;
        stall = 1'b0; jump = 1'b1; jump_target = 32'h300;
        tick();
        checks++; if (halted !== 1'b1 || pc_out !== 32'd20 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0)
            $display("FAIL halt_enter halted %b pc %h valid %b instr %h want 1/14/0/0",
                     halted, pc_out, if_id_valid, if_id_instr); else passed++;
        tick();
        checks++; if (pc_out !== 32'd20 || bus.imem_rd_en !== 1'b0 || halted !== 1'b1)
            $display("FAIL halt_ignore_jump pc %h rd_en %b halted %b want 14/0/1", pc_out, bus.imem_rd_en, halted); else passed++;
        jump = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0; enable = 1'b0;
        #1;
        checks++; if (pc_out !== 32'h0 || halted !== 1'b0 || bus.imem_rd_en !== 1'b0)
            $display("FAIL halt_reset pc %h halted %b rd_en %b want 0/0/0", pc_out, halted, bus.imem_rd_en); else passed++;
        halt_en = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        enable = 1'b1;
        tick();  // RUN
        checks++; if (w_pc_out !== 32'hFFFF_FFFC || wbus.imem_rd_en !== 1'b1)
            $display("FAIL wrap_entry pc %h rd_en %b want fffffffc/1", w_pc_out, wbus.imem_rd_en); else passed++;
        tick();
        checks++; if (w_pc_out !== 32'h0 || w_if_id_pc_plus4 !== 32'h0)
            $display("FAIL wrap_pc pc %h plus4 %h want 0/0", w_pc_out, w_if_id_pc_plus4); else passed++;
        checks++; if (w_if_id_valid !== 1'b1 || w_if_id_instr !== 32'hECA8_FFFC)
            $display("FAIL wrap_instr valid %b instr %h want 1/eca8fffc", w_if_id_valid, w_if_id_instr); else passed++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump_over_stall();
        test_halt();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
